serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub_if.sv | 26 ++
 rtl/serial_addsub.sv | 103 ++++++++++
 tb/tb_serial_addsub.sv | 125 ++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// Request/response bundle for the slice-serial adder/subtractor.
interface serial_addsub_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output start, op, a, b,
    input  busy, done, result, c_out, overflow, zero, negative
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, c_out, overflow, zero, negative
  );
endinterface

// File: rtl/serial_addsub.sv
// Signed add/subtract processed SLICE bits per cycle, LSB slice first.
// Subtraction is a + ~b with the +1 fed in as the initial carry.
module serial_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_addsub_if.slave bus
);
  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned CW = (N + 1 > 1) ? $clog2(N + 1) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [WIDTH-1:0] acc_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             c_out_q;
  logic             overflow_q;
  logic             zero_q;
  logic             negative_q;

  logic [SLICE:0]   sum_c;
  logic [WIDTH-1:0] acc_c;
  logic             msb_cin_c;
  logic             last_c;

  // Operands shift down so the active slice is always the low SLICE bits;
  // each partial sum enters the accumulator from the top.
  always_comb begin
    sum_c     = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]} + (SLICE+1)'(carry_q);
    acc_c     = (acc_q >> SLICE) | (WIDTH'(sum_c[SLICE-1:0]) << (WIDTH - SLICE));
    msb_cin_c = a_q[SLICE-1] ^ b_q[SLICE-1] ^ sum_c[SLICE-1];
    last_c    = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.op ? ~bus.b : bus.b;
            carry_q <= bus.op;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> SLICE;
          b_q     <= b_q >> SLICE;
          carry_q <= sum_c[SLICE];
          acc_q   <= acc_c;
          cnt_q   <= cnt_q + CW'(1);
          if (last_c) begin
            cnt_q      <= '0;
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            result_q   <= acc_c;
            c_out_q    <= sum_c[SLICE];
            overflow_q <= msb_cin_c ^ sum_c[SLICE];
            zero_q     <= (acc_c == '0);
            negative_q <= acc_c[WIDTH-1];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = overflow_q;
  assign bus.zero     = zero_q;
  assign bus.negative = negative_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: 4-slice instance plus a single-slice instance.
module tb_serial_addsub;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  logic [W-1:0] last_res = '0;
  logic [3:0]   last_flags = '0;

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(W)) bus  ();
  serial_addsub_if #(.WIDTH(W)) bus1 ();

  serial_addsub #(.WIDTH(W), .SLICE(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  serial_addsub #(.WIDTH(W), .SLICE(W)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] flags0();
    return {bus.c_out, bus.overflow, bus.zero, bus.negative};
  endfunction

  // flags packed as {c_out, overflow, zero, negative}
  task automatic run_op(input string tag, input logic op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] res,
                        input logic [3:0] flags, input bit disturb);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    @(negedge clk);  // edge k accepted
    check({tag, "_busy_k"}, 64'(bus.busy), 64'd1);
    check({tag, "_done_k"}, 64'(bus.done), 64'd0);
    bus.start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      if (disturb) begin
        bus.start = (i >= 2);
        bus.a = 32'hDEAD_BEEF; bus.b = 32'h0BAD_F00D; bus.op = ~op;
      end
      @(negedge clk);
      check({tag, "_busy_run"}, 64'(bus.busy), 64'd1);
      check({tag, "_done_run"}, 64'(bus.done), 64'd0);
      check({tag, "_hold_res"}, 64'(bus.result), 64'(last_res));
      check({tag, "_hold_flg"}, 64'(flags0()), 64'(last_flags));
    end
    @(negedge clk);  // edge k+4: completion
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
    check({tag, "_result"}, 64'(bus.result), 64'(res));
    check({tag, "_flags"}, 64'(flags0()), 64'(flags));
    bus.start = 1'b0;
    @(negedge clk);
    check({tag, "_done_low"}, 64'(bus.done), 64'd0);
    check({tag, "_idle"}, 64'(bus.busy), 64'd0);
    check({tag, "_res_held"}, 64'(bus.result), 64'(res));
    last_res = res;
    last_flags = flags;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;  bus.op = 1'b0;  bus.a = '0;  bus.b = '0;
    bus1.start = 1'b0; bus1.op = 1'b0; bus1.a = '0; bus1.b = '0;
    #12;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_flags", 64'(flags0()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("sub5_3",  1'b1, 32'd5,         32'd3,         32'd2,         4'b1000, 1'b0);
    run_op("sub3_5",  1'b1, 32'd3,         32'd5,         32'hFFFF_FFFE, 4'b0001, 1'b0);
    run_op("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 4'b0101, 1'b0);
    run_op("sub_ovf", 1'b1, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 4'b1100, 1'b0);
    run_op("sub_zero",1'b1, 32'd7,         32'd7,         32'd0,         4'b1010, 1'b0);
    run_op("add_ff",  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b1001, 1'b0);
    run_op("disturb", 1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 4'b0000, 1'b1);

    // Abort mid-operation with reset between edges k+2 and k+3
    bus.op = 1'b0; bus.a = 32'd9; bus.b = 32'd4; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_result", 64'(bus.result), 64'd0);
    check("abort_flags", 64'(flags0()), 64'd0);
    last_res = '0;
    last_flags = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", 64'(bus.done), 64'd0);
    end
    run_op("fresh", 1'b1, 32'd100, 32'd23, 32'd77, 4'b1000, 1'b0);

    // Single-slice instance: done one edge after acceptance
    bus1.op = 1'b0; bus1.a = 32'h7FFF_FFFF; bus1.b = 32'd1; bus1.start = 1'b1;
    @(negedge clk);
    check("n1_busy", 64'(bus1.busy), 64'd1);
    check("n1_done_k", 64'(bus1.done), 64'd0);
    bus1.start = 1'b0;
    @(negedge clk);
    check("n1_done", 64'(bus1.done), 64'd1);
    check("n1_result", 64'(bus1.result), 64'h8000_0000);
    check("n1_flags", 64'({bus1.c_out, bus1.overflow, bus1.zero, bus1.negative}), 64'b0101);
    @(negedge clk);
    check("n1_done_low", 64'(bus1.done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
